// File: rtl/sun_pll_lockdet.sv
// rtl/sun_pll_lockdet.sv - PLL frequency lock detector counting CK cycles per CK_REF period
// Optional unlock hysteresis: define SUN_PLL_LOCKDET_HYST_EN.
module sun_pll_lockdet #(
   parameter int DIV_RATIO  = 128,
   parameter int TOL        = 2,
   parameter int LOCK_CNT   = 4,
   parameter int UNLOCK_CNT = 2,
   parameter int CNT_W      = 9
) (
   input  logic             CK,
   input  logic             PWRUP_1V8,
   input  logic             CK_REF,
   output logic             LOCK,
   output logic [CNT_W-1:0] FCNT,
   output logic             FCNT_VLD
);
   localparam int                GOOD_W   = $clog2(LOCK_CNT + 1);
   localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0]  WIN_LO   = CNT_W'(DIV_RATIO - TOL);
   localparam logic [CNT_W-1:0]  WIN_HI   = CNT_W'(DIV_RATIO + TOL);
   localparam logic [GOOD_W-1:0] GOOD_MAX = GOOD_W'(LOCK_CNT);

   typedef enum logic [1:0] {IDLE, ACQ, LOCKED} state_t;

   state_t            r_state, w_state_nxt;
   logic              r_sync1, r_sync2, r_dly;
   logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
   logic [GOOD_W-1:0] r_good, w_good_nxt;
   logic              r_lock, w_lock_nxt;
   logic [CNT_W-1:0]  r_fcnt;
   logic              r_fcnt_vld;
   logic              w_ref_rise, w_running, w_sat_hit, w_good_win;

`ifdef SUN_PLL_LOCKDET_HYST_EN
   localparam int                BAD_W   = $clog2(UNLOCK_CNT + 1);
   localparam logic [BAD_W-1:0]  BAD_MAX = BAD_W'(UNLOCK_CNT);
   logic [BAD_W-1:0]  r_bad, w_bad_nxt;
`endif

   assign w_ref_rise = r_sync2 & ~r_dly;
   assign w_running  = (r_state != IDLE);
   // Fires once, on the cycle the counter steps onto its saturated value.
   assign w_sat_hit  = w_running && !w_ref_rise && (r_cnt == CNT_MAX - 1'b1);
   assign w_good_win = (r_cnt >= WIN_LO) && (r_cnt <= WIN_HI) && (r_cnt != CNT_MAX);

   always_comb begin
      w_cnt_nxt = r_cnt;
      if (w_ref_rise)
         w_cnt_nxt = CNT_W'(1);
      else if (w_running && (r_cnt != CNT_MAX))
         w_cnt_nxt = r_cnt + 1'b1;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_good_nxt  = r_good;
      w_lock_nxt  = r_lock;
`ifdef SUN_PLL_LOCKDET_HYST_EN
      w_bad_nxt   = r_bad;
`endif
      case (r_state)
         IDLE: begin
            if (w_ref_rise)
               w_state_nxt = ACQ;
         end
         ACQ: begin
            if (w_sat_hit) begin
               w_good_nxt = '0;
               w_lock_nxt = 1'b0;
`ifdef SUN_PLL_LOCKDET_HYST_EN
               w_bad_nxt  = '0;
`endif
            end else if (w_ref_rise) begin
               if (!w_good_win)
                  w_good_nxt = '0;
               else if (r_good >= GOOD_MAX - 1'b1) begin
                  w_good_nxt  = GOOD_MAX;
                  w_state_nxt = LOCKED;
                  w_lock_nxt  = 1'b1;
               end else
                  w_good_nxt = r_good + 1'b1;
            end
         end
         LOCKED: begin
            if (w_sat_hit) begin
               w_state_nxt = ACQ;
               w_good_nxt  = '0;
               w_lock_nxt  = 1'b0;
`ifdef SUN_PLL_LOCKDET_HYST_EN
               w_bad_nxt   = '0;
`endif
            end else if (w_ref_rise) begin
`ifdef SUN_PLL_LOCKDET_HYST_EN
               if (w_good_win)
                  w_bad_nxt = '0;
               else if (r_bad >= BAD_MAX - 1'b1) begin
                  w_state_nxt = ACQ;
                  w_good_nxt  = '0;
                  w_bad_nxt   = '0;
                  w_lock_nxt  = 1'b0;
               end else
                  w_bad_nxt = r_bad + 1'b1;
`else
               if (!w_good_win) begin
                  w_state_nxt = ACQ;
                  w_good_nxt  = '0;
                  w_lock_nxt  = 1'b0;
               end
`endif
            end
         end
         default: begin
            w_state_nxt = IDLE;
            w_good_nxt  = '0;
            w_lock_nxt  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge CK or negedge PWRUP_1V8) begin
      if (!PWRUP_1V8) begin
         r_sync1    <= 1'b0;
         r_sync2    <= 1'b0;
         r_dly      <= 1'b0;
         r_cnt      <= '0;
         r_state    <= IDLE;
         r_good     <= '0;
         r_lock     <= 1'b0;
         r_fcnt     <= '0;
         r_fcnt_vld <= 1'b0;
      end else begin
         r_sync1    <= CK_REF;
         r_sync2    <= r_sync1;
         r_dly      <= r_sync2;
         r_cnt      <= w_cnt_nxt;
         r_state    <= w_state_nxt;
         r_good     <= w_good_nxt;
         r_lock     <= w_lock_nxt;
         r_fcnt_vld <= w_ref_rise && w_running;
         if (w_ref_rise && w_running)
            r_fcnt <= r_cnt;
      end
   end

`ifdef SUN_PLL_LOCKDET_HYST_EN
   always_ff @(posedge CK or negedge PWRUP_1V8) begin
      if (!PWRUP_1V8)
         r_bad <= '0;
      else
         r_bad <= w_bad_nxt;
   end
`endif

   assign LOCK     = r_lock;
   assign FCNT     = r_fcnt;
   assign FCNT_VLD = r_fcnt_vld;
endmodule
